// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
// Holds funct3 op codes, FSM state encoding and the iteration count.
package muldiv_pkg;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam int NUM_ITER = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_sign.sv
// Operand sign handling for RV32M: magnitudes, result-negate flags and the
// divide-by-zero / signed-overflow fast-path result.
module muldiv_sign
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] mag_a,
  output logic [WIDTH-1:0] mag_b,
  output logic             neg_prod,
  output logic             neg_quot,
  output logic             neg_rem,
  output logic             special,
  output logic [WIDTH-1:0] special_val
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

  logic is_div;
  logic a_signed;
  logic b_signed;
  logic sa;
  logic sb;
  logic div_zero;
  logic div_ovf;

  assign is_div   = funct3[2];
  // Divide ops are signed when funct3[0]==0; MULHSU keeps only rs1 signed.
  assign a_signed = is_div ? ~funct3[0] : (funct3 != F_MULHU);
  assign b_signed = is_div ? ~funct3[0] : (funct3 == F_MUL || funct3 == F_MULH);
  assign sa       = a_signed & op_a[WIDTH-1];
  assign sb       = b_signed & op_b[WIDTH-1];

  assign mag_a    = sa ? -op_a : op_a;
  assign mag_b    = sb ? -op_b : op_b;
  assign neg_prod = ~is_div & (sa ^ sb);
  assign neg_quot = is_div & (sa ^ sb);
  assign neg_rem  = is_div & sa;

  assign div_zero = is_div & (op_b == '0);
  assign div_ovf  = is_div & ~funct3[0] & (op_a == MIN_NEG) & (op_b == ALL_ONE);
  assign special  = div_zero | div_ovf;

  always_comb begin
    special_val = '0;
    if (div_zero)
      special_val = funct3[1] ? op_a : ALL_ONE;
    else if (div_ovf)
      special_val = funct3[1] ? '0 : MIN_NEG;
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: one radix-2
// shift-add or restoring-divide step per cycle, with a fast path for specials.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opnd;
  logic [2:0]           f3_q;
  logic                 neg_prod_q, neg_quot_q, neg_rem_q;
  logic                 done_q;
  logic [WIDTH-1:0]     result_q;

  logic [WIDTH-1:0]     mag_a, mag_b, special_val;
  logic                 neg_prod, neg_quot, neg_rem, special;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   acc_next;
  logic                 last;

  muldiv_sign #(.WIDTH(WIDTH)) u_sign (
    .funct3      (funct3),
    .op_a        (op_a),
    .op_b        (op_b),
    .mag_a       (mag_a),
    .mag_b       (mag_b),
    .neg_prod    (neg_prod),
    .neg_quot    (neg_quot),
    .neg_rem     (neg_rem),
    .special     (special),
    .special_val (special_val)
  );

  // Apply the latched sign corrections and pick the half the op returns.
  function automatic logic [WIDTH-1:0] finish_result(
    input logic [2:0]         f3,
    input logic [2*WIDTH-1:0] a,
    input logic               np,
    input logic               nq,
    input logic               nr
  );
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    prod = np ? -a : a;
    quo  = nq ? -a[WIDTH-1:0] : a[WIDTH-1:0];
    rem  = nr ? -a[2*WIDTH-1:WIDTH] : a[2*WIDTH-1:WIDTH];
    case (f3)
      F_MUL:                     finish_result = prod[WIDTH-1:0];
      F_MULH, F_MULHSU, F_MULHU: finish_result = prod[2*WIDTH-1:WIDTH];
      F_DIV, F_DIVU:             finish_result = quo;
      default:                   finish_result = rem;
    endcase
  endfunction

  // Multiply: acc = {partial hi, remaining multiplier}, shifted right each step.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next  = {mul_sum, acc[WIDTH-1:1]};
  // Divide: acc = {partial remainder, dividend/quotient}, shifted left each step.
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_next  = {div_rem, acc[WIDTH-2:0], div_ge};
  assign acc_next  = f3_q[2] ? div_next : mul_next;
  assign last      = (cnt == CNT_W'(NUM_ITER - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = special ? DONE : CALC;
      CALC:    if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  assign busy   = ~flush & (((state == IDLE) & start) | (state == CALC));
  assign done   = done_q;
  assign result = result_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      done_q     <= 1'b0;
      result_q   <= '0;
      acc        <= '0;
      opnd       <= '0;
      f3_q       <= '0;
      neg_prod_q <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start && !flush) begin
            f3_q       <= funct3;
            neg_prod_q <= neg_prod;
            neg_quot_q <= neg_quot;
            neg_rem_q  <= neg_rem;
            cnt        <= '0;
            acc        <= funct3[2] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
            opnd       <= funct3[2] ? mag_b : mag_a;
            if (special) result_q <= special_val;
          end
        end
        CALC: begin
          if (!flush) begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
            if (last)
              result_q <= finish_result(f3_q, acc_next, neg_prod_q, neg_quot_q, neg_rem_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv: latency, results, specials,
// flush/reset kill and back-to-back issue.
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  ex_muldiv dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one op at the current cycle (cycle 0) with start held until done.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int   cyc     = 0;
    logic busy_ok = 1'b1;
    logic seen    = 1'b0;
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      cyc++;
      next_cycle();
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_busy_span"}, 32'(busy_ok), 32'd1);
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    check({tag, "_result"}, result, exp_res);
    start = 1'b0;
    next_cycle();
    @(negedge clk);
    check({tag, "_done_after"}, 32'(done), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_result_held"}, result, exp_res);
    next_cycle();
  endtask

  initial begin
    int   cyc;
    int   first;
    int   second;
    logic busy34;
    logic ok;

    rst = 1'b1; flush = 1'b0; start = 1'b0;
    funct3 = 3'b000; op_a = '0; op_b = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'h0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    run_op("mul",    F_MUL,    32'd7,        32'd6,        32'h0000002A, 33);
    run_op("mulh",   F_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulhu",  F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulhsu", F_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
    run_op("div",    F_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem",    F_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu",   F_DIVU,   32'd100,      32'd7,        32'd14,       33);
    run_op("remu",   F_REMU,   32'd100,      32'd7,        32'd2,        33);
    run_op("div_ovf", F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf", F_REM,   32'h80000000, 32'hFFFFFFFF, 32'h0,        1);
    run_op("divu_z", F_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("remu_z", F_REMU,   32'd5,        32'd0,        32'd5,        1);

    // Flush in cycle 10 of a DIVU: no done, result keeps 5.
    funct3 = F_DIVU; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0) ok = 1'b0;
      next_cycle();
    end
    check("flush_pre_busy", 32'(ok), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    check("flush_busy", 32'(busy), 32'd0);
    next_cycle();
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", 32'(busy), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      @(negedge clk);
      if (done !== 1'b0) ok = 1'b0;
    end
    check("flush_no_done", 32'(ok), 32'd1);
    check("flush_result_kept", result, 32'd5);
    next_cycle();

    // Reset in cycle 10 of a DIVU clears the result.
    funct3 = F_DIVU; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    for (int i = 0; i < 10; i++) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_result", result, 32'h0);
    next_cycle();

    // Back-to-back: MUL 3x5 then DIVU 20/4 with start held throughout.
    funct3 = F_MUL; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    cyc = 0; first = -1; second = -1; busy34 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cyc == 34) busy34 = busy;
      if (done) begin
        if (first < 0) begin
          first = cyc;
          check("b2b_first_result", result, 32'd15);
          funct3 = F_DIVU; op_a = 32'd20; op_b = 32'd4;
        end else begin
          second = cyc;
          check("b2b_second_result", result, 32'd5);
          break;
        end
      end
      cyc++;
      next_cycle();
    end
    check("b2b_first_cycle", 32'(first), 32'd33);
    check("b2b_accept_busy", 32'(busy34), 32'd1);
    check("b2b_second_cycle", 32'(second), 32'd67);
    start = 1'b0;
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the EX stage.
- Consumes the decoded M-op fields and forwarded operands held in the ID/EX pipeline register.
- Drives busy back to the hazard logic, which stalls IF, ID and ID/EX while an operation is in flight.
- Produces a 32-bit result for the EX/MEM register on a one-cycle done pulse.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  kill the operation in progress (exception/redirect from a later stage).
- start  input  1  EX holds a valid M-extension instruction (decoded from ctl_EX).
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  32  rs1 value after forwarding.
- op_b  input  32  rs2 value after forwarding.
- busy  output  1  stall request to the pipeline; combinational.
- done  output  1  result valid this cycle; registered, one-cycle pulse.
- result  output  32  registered result; held until the next done.

Behaviour:
- Reset: rst=1 at an edge gives state IDLE, counter 0, done 0, result 0, internal accumulators 0. rst has priority over flush and start.
- States and transitions:
  - IDLE: start=1 latches funct3, operand magnitudes and sign flags. A special case (below) goes to DONE; otherwise go to CALC with counter=0.
  - CALC: performs one radix-2 step per cycle and increments the counter. After the 32nd step (counter==31 at the edge) go to DONE.
  - DONE: done=1 and result valid; return to IDLE unconditionally. start is ignored in DONE, so the stalled instruction is never reissued.
- busy = ~flush & ((state==IDLE & start) | state==CALC). busy is 0 in DONE, so the pipeline advances on the DONE edge.
- Latency: start seen in IDLE at cycle 0; CALC occupies cycles 1..32; done in cycle 33. busy is high for 33 cycles. A back-to-back M op arriving in the next IDLE cycle is accepted immediately.
- Multiply:
  - Shift-add on |a| x |b|, 64-bit accumulator.
  - Sign rules: MUL/MULH treat both operands as signed; MULHSU treats a signed, b unsigned; MULHU treats both unsigned.
  - Negate the 64-bit product if the operand signs differ (signed operands only).
  - MUL returns the low 32 bits; MULH* return the high 32 bits.
- Divide:
  - Restoring division on magnitudes.
  - Quotient sign = sa^sb for DIV; remainder sign = sign of dividend for REM. DIVU and REMU are unsigned.
- Special cases (fast path, IDLE -> DONE, done in cycle 1, busy high for cycle 0 only):
  - divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a.
  - DIV with 0x80000000 / 0xFFFFFFFF gives 0x80000000; the matching REM gives 0.
- Flush: in any state, next state is IDLE. done is not asserted for the killed op, result is unchanged, and busy is forced 0 in the flush cycle. start in the same cycle as flush is ignored.
- The result register is written only on entry to DONE.

Decomposition:
- Package muldiv_pkg:
  - funct3 localparams (F_MUL .. F_REMU).
  - State encoding: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - NUM_ITER=32.
- One sub-module, muldiv_sign (combinational):
  - Inputs: funct3, op_a, op_b.
  - Outputs: |a|, |b|, the negate-product / negate-quotient / negate-remainder flags, and the special-case flag with its value.
- The FSM, counter and datapath stay in ex_muldiv.

Test Plan:
- MUL, a=7, b=6, start held -> busy high for cycles 0..32; done=1 in cycle 33 with result=0x0000002A; then busy=0 and done=0.
- MULH, a=b=0x80000000 -> result 0x40000000. MULHU, a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU, a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV, a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU, a=100, b=7 -> 14. REMU with the same operands -> 2. Each completes in cycle 33.
- DIVU, a=5, b=0 -> done in cycle 1 with 0xFFFFFFFF. REMU with the same operands -> 5. DIV, a=0x80000000, b=0xFFFFFFFF -> 0x80000000 in cycle 1. REM with the same operands -> 0.
- DIVU started, then flush=1 in cycle 10 -> busy=0 in cycle 10, IDLE in cycle 11, no done pulse, result keeps its previous value. Repeat with rst=1 in cycle 10 -> result=0.
- MUL (3x5), then DIVU (20/4) with start continuously high -> first done in cycle 33 with result 15; DIVU accepted in cycle 34; second done in cycle 67 with result 5.
